// File: rtl/id_jump_ctrl.sv
// PC redirect sequencer for jumps/taken branches resolved in ID.
// Waits for the delay-slot fetch, then hands one redirect to IF via valid/ready.
module id_jump_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_jump_valid,
  input  logic              id_advance,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              if_fetch_done,
  input  logic              flush,
  input  logic              redirect_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              redirect_misalign,
  output logic              jump_busy,
  output logic [CNT_W-1:0]  redirect_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    REDIR     = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              accept;
  logic              transfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    transfer   = 1'b0;
    // flush wins over any accept or transfer in the same cycle
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (id_jump_valid && id_advance) begin
            accept     = 1'b1;
            state_next = if_fetch_done ? REDIR : WAIT_SLOT;
          end
        end
        WAIT_SLOT: begin
          if (if_fetch_done) begin
            state_next = REDIR;
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            transfer   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      if (accept) begin
        pc_reg <= id_target;
      end
      if (transfer && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign redirect_valid    = (state_reg == REDIR);
  assign jump_busy         = (state_reg != IDLE);
  assign redirect_pc       = pc_reg;
  assign redirect_misalign = |pc_reg[1:0];
  assign redirect_cnt      = cnt_reg;

endmodule
